// File: rtl/ip_packet_rx.sv
// rtl/ip_packet_rx.sv - Ethernet/IPv4 receive parser and filter for accelerator messages
//
// Parses the fixed 60-byte Ethernet+IPv4 frame produced by the accelerator TX
// path. It checks the destination address, the type fields and the header
// checksum. For an accepted frame it presents the sender's IP/MAC and the
// 10-bit message on a valid/ready handshake.
//
// Ports:
//   ACLK                    in   1  clock, rising edge
//   ARESET                  in   1  asynchronous active-low reset
//   ACCELERATOR_IP_ADDRESS  in  32  local IP, must equal frame dst IP
//   ACCELERATOR_MAC_ADDRESS in  48  local MAC, frame dst MAC must match or be broadcast
//   MAC_DATA_IN             in   8  RX byte
//   MAC_DATA_VALID          in   1  RX byte valid
//   MAC_DATA_READY          out  1  RX byte accepted on VALID & READY
//   MAC_DATA_LAST           in   1  last byte of frame
//   MAC_DATA_TUSER          in   1  MAC error flag, meaningful with LAST only
//   SENDER_IP_ADDRESS       out 32  src IP of accepted frame
//   SENDER_MAC_ADDRESS      out 48  src MAC of accepted frame
//   RECEIVED_MESSAGE        out 10  message of accepted frame
//   MESSAGE_VALID           out  1  message outputs valid, held until MESSAGE_READY
//   MESSAGE_READY           in   1  accelerator consumes message
//   RX_DROP                 out  1  one-cycle pulse, frame rejected
module ip_packet_rx #(
   parameter logic [15:0] ETH_TYPE    = 16'h8000,
   parameter logic [7:0]  IP_PROTOCOL = 8'h04,
   parameter logic [15:0] IP_LENGTH   = 16'd46,
   parameter int          FRAME_BYTES = 60
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [31:0] ACCELERATOR_IP_ADDRESS,
   input  logic [47:0] ACCELERATOR_MAC_ADDRESS,
   input  logic [7:0]  MAC_DATA_IN,
   input  logic        MAC_DATA_VALID,
   output logic        MAC_DATA_READY,
   input  logic        MAC_DATA_LAST,
   input  logic        MAC_DATA_TUSER,
   output logic [31:0] SENDER_IP_ADDRESS,
   output logic [47:0] SENDER_MAC_ADDRESS,
   output logic [9:0]  RECEIVED_MESSAGE,
   output logic        MESSAGE_VALID,
   input  logic        MESSAGE_READY,
   output logic        RX_DROP
);

   localparam logic [5:0] LAST_IDX = 6'(FRAME_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_DATA,
      S_DISCARD,
      S_HOLD
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic        r_ready;
   logic        r_drop;
   logic        r_valid;
   logic [5:0]  r_cnt;
   logic        r_err;
   logic        r_mac_uc;
   logic        r_mac_bc;
   logic [7:0]  r_hi;
   logic [15:0] r_sum;
   logic [47:0] r_src_mac;
   logic [31:0] r_src_ip;
   logic [9:0]  r_msg;
   logic [31:0] r_out_ip;
   logic [47:0] r_out_mac;
   logic [9:0]  r_out_msg;

   logic        w_beat;
   logic        w_rx;
   logic [5:0]  w_idx;
   logic [47:0] w_mac_sh;
   logic [31:0] w_ip_sh;
   logic [1:0]  w_ip_off;
   logic        w_dmac_hit;
   logic        w_dmac_bc;
   logic        w_field_bad;
   logic [15:0] w_word;
   logic [16:0] w_sum_full;
   logic [15:0] w_sum_next;
   logic        w_frame_ok;
   logic        w_drop;
   logic        w_accept;

   assign w_beat = MAC_DATA_VALID & r_ready;
   // Field parsing only while a frame is being mapped; DISCARD just drains.
   assign w_rx   = w_beat & ((r_state == S_IDLE) | (r_state == S_HEADER) | (r_state == S_DATA));
   // The IDLE beat is byte 0 of the frame.
   assign w_idx  = (r_state == S_IDLE) ? 6'd0 : r_cnt;

   // Address bytes arrive least-significant byte first.
   assign w_mac_sh   = ACCELERATOR_MAC_ADDRESS >> {w_idx[2:0], 3'b000};
   assign w_ip_off   = w_idx[1:0] - 2'd2;  // bytes 30..33 -> 0..3
   assign w_ip_sh    = ACCELERATOR_IP_ADDRESS >> {w_ip_off, 3'b000};
   assign w_dmac_hit = (MAC_DATA_IN == w_mac_sh[7:0]);
   assign w_dmac_bc  = (MAC_DATA_IN == 8'hFF);

   // The IP address fields arrive low byte first, so their checksum words are
   // reassembled byte-swapped to obtain the numeric 16-bit halves.
   assign w_word     = (w_idx >= 6'd27) ? {MAC_DATA_IN, r_hi} : {r_hi, MAC_DATA_IN};
   assign w_sum_full = {1'b0, r_sum} + {1'b0, w_word};
   assign w_sum_next = w_sum_full[15:0] + {15'd0, w_sum_full[16]};

   assign w_frame_ok = (r_mac_uc | r_mac_bc) & ~r_err & (r_sum == 16'hFFFF) & ~MAC_DATA_TUSER;

   always_comb begin
      w_field_bad = 1'b0;
      case (w_idx)
         6'd12:                     w_field_bad = (MAC_DATA_IN != ETH_TYPE[15:8]);
         6'd13:                     w_field_bad = (MAC_DATA_IN != ETH_TYPE[7:0]);
         6'd14:                     w_field_bad = (MAC_DATA_IN != 8'h45);
         6'd16:                     w_field_bad = (MAC_DATA_IN != IP_LENGTH[15:8]);
         6'd17:                     w_field_bad = (MAC_DATA_IN != IP_LENGTH[7:0]);
         6'd23:                     w_field_bad = (MAC_DATA_IN != IP_PROTOCOL);
         6'd30, 6'd31, 6'd32, 6'd33: w_field_bad = (MAC_DATA_IN != w_ip_sh[7:0]);
         default:                   w_field_bad = 1'b0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_drop   = 1'b0;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_beat) begin
               if (MAC_DATA_LAST) begin
                  w_drop = 1'b1;
               end else begin
                  w_next = S_HEADER;
               end
            end
         end
         S_HEADER, S_DATA: begin
            if (w_beat) begin
               if (r_cnt == LAST_IDX) begin
                  if (!MAC_DATA_LAST) begin
                     w_next = S_DISCARD;
                  end else if (w_frame_ok) begin
                     w_next   = S_HOLD;
                     w_accept = 1'b1;
                  end else begin
                     w_next = S_IDLE;
                     w_drop = 1'b1;
                  end
               end else if (MAC_DATA_LAST) begin
                  w_next = S_IDLE;
                  w_drop = 1'b1;
               end else if (r_cnt >= 6'd33) begin
                  w_next = S_DATA;
               end else begin
                  w_next = S_HEADER;
               end
            end
         end
         S_DISCARD: begin
            if (w_beat && MAC_DATA_LAST) begin
               w_next = S_IDLE;
               w_drop = 1'b1;
            end
         end
         S_HOLD: begin
            // MESSAGE_VALID is always high in HOLD.
            if (MESSAGE_READY) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_ready   <= 1'b0;
         r_drop    <= 1'b0;
         r_valid   <= 1'b0;
         r_cnt     <= 6'd0;
         r_err     <= 1'b0;
         r_mac_uc  <= 1'b0;
         r_mac_bc  <= 1'b0;
         r_hi      <= 8'd0;
         r_sum     <= 16'd0;
         r_src_mac <= 48'd0;
         r_src_ip  <= 32'd0;
         r_msg     <= 10'd0;
         r_out_ip  <= 32'd0;
         r_out_mac <= 48'd0;
         r_out_msg <= 10'd0;
      end else begin
         r_ready <= (w_next != S_HOLD);
         r_drop  <= w_drop;

         if (w_accept) begin
            r_valid   <= 1'b1;
            r_out_ip  <= r_src_ip;
            r_out_mac <= r_src_mac;
            r_out_msg <= r_msg;
         end else if ((r_state == S_HOLD) && MESSAGE_READY) begin
            r_valid <= 1'b0;
         end

         if (w_rx) begin
            r_cnt <= w_idx + 6'd1;
            if (w_idx == 6'd0) begin
               r_err    <= 1'b0;
               r_sum    <= 16'd0;
               r_mac_uc <= w_dmac_hit;
               r_mac_bc <= w_dmac_bc;
            end else begin
               if (w_idx <= 6'd5) begin
                  r_mac_uc <= r_mac_uc & w_dmac_hit;
                  r_mac_bc <= r_mac_bc & w_dmac_bc;
               end
               if (w_field_bad) begin
                  r_err <= 1'b1;
               end
               if ((w_idx >= 6'd15) && (w_idx <= 6'd33) && w_idx[0]) begin
                  r_sum <= w_sum_next;
               end
            end
            if (!w_idx[0]) begin
               r_hi <= MAC_DATA_IN;
            end
            // Shift in from the top so the first byte lands in bits [7:0].
            if ((w_idx >= 6'd6) && (w_idx <= 6'd11)) begin
               r_src_mac <= {MAC_DATA_IN, r_src_mac[47:8]};
            end
            if ((w_idx >= 6'd26) && (w_idx <= 6'd29)) begin
               r_src_ip <= {MAC_DATA_IN, r_src_ip[31:8]};
            end
            if (w_idx == 6'd34) begin
               r_msg[9:8] <= MAC_DATA_IN[1:0];
            end
            if (w_idx == 6'd35) begin
               r_msg[7:0] <= MAC_DATA_IN;
            end
         end
      end
   end

   assign MAC_DATA_READY     = r_ready;
   assign RX_DROP            = r_drop;
   assign MESSAGE_VALID      = r_valid;
   assign SENDER_IP_ADDRESS  = r_out_ip;
   assign SENDER_MAC_ADDRESS = r_out_mac;
   assign RECEIVED_MESSAGE   = r_out_msg;

endmodule

// File: tb/tb_ip_packet_rx.sv
// tb/tb_ip_packet_rx.sv - directed self-checking bench for ip_packet_rx
module tb_ip_packet_rx;

   localparam logic [31:0] LOCAL_IP  = 32'hbeefbeef;
   localparam logic [47:0] LOCAL_MAC = 48'h54b00bedabba;
   localparam logic [31:0] SRC_IP    = 32'hdeadbeef;
   localparam logic [47:0] SRC_MAC   = 48'h32dabbadebd5;
   localparam logic [47:0] BCAST     = 48'hffffffffffff;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b0;
   logic [7:0]  MAC_DATA_IN = 8'd0;
   logic        MAC_DATA_VALID = 1'b0;
   logic        MAC_DATA_READY;
   logic        MAC_DATA_LAST = 1'b0;
   logic        MAC_DATA_TUSER = 1'b0;
   logic [31:0] SENDER_IP_ADDRESS;
   logic [47:0] SENDER_MAC_ADDRESS;
   logic [9:0]  RECEIVED_MESSAGE;
   logic        MESSAGE_VALID;
   logic        MESSAGE_READY = 1'b0;
   logic        RX_DROP;

   int          n_checks = 0;
   int          n_errors = 0;
   int          drop_cnt = 0;
   int          drop_base;
   logic [7:0]  fr [0:69];
   int          gap [0:69];

   ip_packet_rx dut (
      .ACLK                    (ACLK),
      .ARESET                  (ARESET),
      .ACCELERATOR_IP_ADDRESS  (LOCAL_IP),
      .ACCELERATOR_MAC_ADDRESS (LOCAL_MAC),
      .MAC_DATA_IN             (MAC_DATA_IN),
      .MAC_DATA_VALID          (MAC_DATA_VALID),
      .MAC_DATA_READY          (MAC_DATA_READY),
      .MAC_DATA_LAST           (MAC_DATA_LAST),
      .MAC_DATA_TUSER          (MAC_DATA_TUSER),
      .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
      .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
      .RECEIVED_MESSAGE        (RECEIVED_MESSAGE),
      .MESSAGE_VALID           (MESSAGE_VALID),
      .MESSAGE_READY           (MESSAGE_READY),
      .RX_DROP                 (RX_DROP)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge ACLK) begin
      if (RX_DROP) begin
         drop_cnt++;
         check("drop_with_valid", {63'd0, MESSAGE_VALID}, 64'd0);
      end
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   function automatic logic [15:0] ip_cksum(input logic [31:0] s, input logic [31:0] d);
      logic [31:0] sum;
      sum = 32'h4500 + 32'h002e + 32'h0000 + 32'h0000 + 32'h4004
          + {16'd0, s[31:16]} + {16'd0, s[15:0]} + {16'd0, d[31:16]} + {16'd0, d[15:0]};
      sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
      sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
      return ~sum[15:0];
   endfunction

   task automatic build(input logic [47:0] dmac, input logic [31:0] sip,
                        input logic [31:0] dip, input logic [9:0] msg);
      logic [15:0] ck;
      ck = ip_cksum(sip, dip);
      for (int i = 0; i < 70; i++) fr[i] = 8'h00;
      for (int i = 0; i < 6; i++) begin
         fr[i]     = dmac[8*i +: 8];
         fr[6 + i] = SRC_MAC[8*i +: 8];
      end
      fr[12] = 8'h80; fr[13] = 8'h00;
      fr[14] = 8'h45; fr[16] = 8'h00; fr[17] = 8'h2e;
      fr[22] = 8'h40; fr[23] = 8'h04;
      fr[24] = ck[15:8]; fr[25] = ck[7:0];
      for (int i = 0; i < 4; i++) begin
         fr[26 + i] = sip[8*i +: 8];
         fr[30 + i] = dip[8*i +: 8];
      end
      fr[34] = {6'd0, msg[9:8]};
      fr[35] = msg[7:0];
   endtask

   task automatic clear_gaps();
      for (int i = 0; i < 70; i++) gap[i] = 0;
   endtask

   task automatic send_frame(input int nbytes, input int last_at, input logic tuser_last);
      int wait_cnt;
      for (int i = 0; i < nbytes; i++) begin
         if (gap[i] > 0) begin
            MAC_DATA_VALID = 1'b0;
            MAC_DATA_LAST  = 1'b0;
            repeat (gap[i]) tick();
         end
         MAC_DATA_IN    = fr[i];
         MAC_DATA_VALID = 1'b1;
         MAC_DATA_LAST  = (i == last_at);
         MAC_DATA_TUSER = (i == last_at) ? tuser_last : 1'b0;
         wait_cnt = 0;
         while (!MAC_DATA_READY && wait_cnt < 300) begin
            tick();
            wait_cnt++;
         end
         if (!MAC_DATA_READY) begin
            check("rx_ready_timeout", 64'd0, 64'd1);
            MAC_DATA_VALID = 1'b0;
            MAC_DATA_LAST  = 1'b0;
            return;
         end
         tick();
      end
      MAC_DATA_VALID = 1'b0;
      MAC_DATA_LAST  = 1'b0;
      MAC_DATA_TUSER = 1'b0;
   endtask

   task automatic expect_accept(input string tag, input logic [47:0] mac, input logic [9:0] msg);
      check({tag, "_valid"}, {63'd0, MESSAGE_VALID}, 64'd1);
      check({tag, "_ip"}, {32'd0, SENDER_IP_ADDRESS}, {32'd0, SRC_IP});
      check({tag, "_mac"}, {16'd0, SENDER_MAC_ADDRESS}, {16'd0, mac});
      check({tag, "_msg"}, {54'd0, RECEIVED_MESSAGE}, {54'd0, msg});
      check({tag, "_nodrop"}, {63'd0, RX_DROP}, 64'd0);
      check({tag, "_stall"}, {63'd0, MAC_DATA_READY}, 64'd0);
   endtask

   task automatic consume(input string tag);
      MESSAGE_READY = 1'b1;
      tick();
      MESSAGE_READY = 1'b0;
      check({tag, "_valid_low"}, {63'd0, MESSAGE_VALID}, 64'd0);
      check({tag, "_ready_back"}, {63'd0, MAC_DATA_READY}, 64'd1);
   endtask

   task automatic expect_drop(input string tag);
      check({tag, "_drop"}, {63'd0, RX_DROP}, 64'd1);
      check({tag, "_novalid"}, {63'd0, MESSAGE_VALID}, 64'd0);
      tick();
      check({tag, "_drop_pulse"}, {63'd0, RX_DROP}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_gaps();
      repeat (3) tick();
      check("rst_ready", {63'd0, MAC_DATA_READY}, 64'd0);
      check("rst_valid", {63'd0, MESSAGE_VALID}, 64'd0);
      check("rst_drop", {63'd0, RX_DROP}, 64'd0);
      check("rst_ip", {32'd0, SENDER_IP_ADDRESS}, 64'd0);
      ARESET = 1'b1;
      check("rel_ready_0", {63'd0, MAC_DATA_READY}, 64'd0);
      tick();
      check("rel_ready_1", {63'd0, MAC_DATA_READY}, 64'd1);

      // T1: nominal frame, continuous VALID
      build(LOCAL_MAC, SRC_IP, LOCAL_IP, 10'h1ff);
      send_frame(60, 59, 1'b0);
      expect_accept("t1", SRC_MAC, 10'h1ff);
      consume("t1");

      // T2: VALID gaps inside the frame
      gap[4] = 1; gap[5] = 2; gap[6] = 3; gap[7] = 4; gap[20] = 5; gap[33] = 6;
      send_frame(60, 59, 1'b0);
      expect_accept("t2", SRC_MAC, 10'h1ff);
      consume("t2");
      clear_gaps();

      // T3: checksum corruption, wrong dst IP, TUSER on LAST
      fr[25] = fr[25] ^ 8'h01;
      send_frame(60, 59, 1'b0);
      expect_drop("t3_cksum");
      build(LOCAL_MAC, SRC_IP, 32'hdeadbeef, 10'h1ff);
      send_frame(60, 59, 1'b0);
      expect_drop("t3_dstip");
      build(LOCAL_MAC, SRC_IP, LOCAL_IP, 10'h1ff);
      send_frame(60, 59, 1'b1);
      expect_drop("t3_tuser");

      // T4: short frame, long frame, then normal
      send_frame(41, 40, 1'b0);
      expect_drop("t4_short");
      drop_base = drop_cnt;
      send_frame(70, 69, 1'b0);
      expect_drop("t4_long");
      tick();
      check("t4_long_one_drop", 64'(drop_cnt - drop_base), 64'd1);
      send_frame(60, 59, 1'b0);
      expect_accept("t4_after", SRC_MAC, 10'h1ff);
      consume("t4_after");

      // T5: back-to-back frames with a slow consumer
      build(LOCAL_MAC, SRC_IP, LOCAL_IP, 10'h155);
      send_frame(60, 59, 1'b0);
      expect_accept("t5a", SRC_MAC, 10'h155);
      build(LOCAL_MAC, SRC_IP, LOCAL_IP, 10'h2aa);
      fork
         send_frame(60, 59, 1'b0);
         begin
            for (int k = 0; k < 5; k++) begin
               check("t5_hold_ready", {63'd0, MAC_DATA_READY}, 64'd0);
               check("t5_hold_valid", {63'd0, MESSAGE_VALID}, 64'd1);
               check("t5_hold_msg", {54'd0, RECEIVED_MESSAGE}, 64'h155);
               tick();
            end
            MESSAGE_READY = 1'b1;
            tick();
            MESSAGE_READY = 1'b0;
         end
      join
      expect_accept("t5b", SRC_MAC, 10'h2aa);
      consume("t5b");

      // T6: reset mid-frame, then normal and broadcast frames
      build(LOCAL_MAC, SRC_IP, LOCAL_IP, 10'h1ff);
      drop_base = drop_cnt;
      send_frame(21, -1, 1'b0);
      ARESET = 1'b0;
      #1;
      check("t6_rst_ready", {63'd0, MAC_DATA_READY}, 64'd0);
      check("t6_rst_ip", {32'd0, SENDER_IP_ADDRESS}, 64'd0);
      check("t6_rst_mac", {16'd0, SENDER_MAC_ADDRESS}, 64'd0);
      check("t6_rst_msg", {54'd0, RECEIVED_MESSAGE}, 64'd0);
      repeat (2) tick();
      check("t6_rst_valid", {63'd0, MESSAGE_VALID}, 64'd0);
      check("t6_rst_drop", {63'd0, RX_DROP}, 64'd0);
      ARESET = 1'b1;
      tick();
      check("t6_rel_ready", {63'd0, MAC_DATA_READY}, 64'd1);
      send_frame(60, 59, 1'b0);
      expect_accept("t6", SRC_MAC, 10'h1ff);
      consume("t6");
      check("t6_no_drop", 64'(drop_cnt - drop_base), 64'd0);
      build(BCAST, SRC_IP, LOCAL_IP, 10'h0a5);
      send_frame(60, 59, 1'b0);
      expect_accept("t6_bcast", SRC_MAC, 10'h0a5);
      consume("t6_bcast");

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
